trap_csr_u: RTL

Machine-mode trap/CSR unit directly downstream of the exception controller. It consumes exception_cause/epc/tval and records the trap in mepc/mcause/mtval/mstatus. It redirects fetch to mtvec and holds a pipeline flush window; it also serves mret and Zicsr read/modify/write accesses to the M-mode trap CSRs.

---
 rtl/trap_csr_u_if.sv | 29 ++
 rtl/trap_csr_u.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/trap_csr_u_if.sv
// Trap/CSR unit bus: exception report, mret, Zicsr access and redirect/flush results.
// The master drives the requests and the slave (trap_csr_u) returns the results.
interface trap_csr_u_if;
  logic [1:0]  exception_cause;
  logic [31:0] exception_epc;
  logic [31:0] exception_tval;
  logic        mret;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] mepc_out;
  logic        mstatus_mie;

  modport master (
    output exception_cause, exception_epc, exception_tval, mret,
           csr_op, csr_addr, csr_wdata,
    input  csr_rdata, redirect, redirect_pc, flush, mepc_out, mstatus_mie
  );

  modport slave (
    input  exception_cause, exception_epc, exception_tval, mret,
           csr_op, csr_addr, csr_wdata,
    output csr_rdata, redirect, redirect_pc, flush, mepc_out, mstatus_mie
  );
endinterface

// File: rtl/trap_csr_u.sv
// Machine-mode trap/CSR unit: records traps, serves mret and Zicsr accesses,
// and redirects fetch while holding a flush window of FLUSH_CYCLES cycles.
module trap_csr_u #(
  parameter logic [1:0]  NOT_EXCEPTION       = 2'b00,
  parameter logic [1:0]  I_ADDR_MISALIGNMENT = 2'b01,
  parameter logic [1:0]  ILLEGAL_IR          = 2'b10,
  parameter logic [31:0] MTVEC_RESET         = 32'h0001_0100,
  parameter int unsigned FLUSH_CYCLES        = 2
) (
  input logic         clk,
  input logic         rst_n,
  trap_csr_u_if.slave bus
);
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [1:0]  FLUSH_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  typedef enum logic [1:0] {RUN, REDIRECT, FLUSH} state_t;

  state_t      state;
  logic [1:0]  flush_cnt;
  logic [31:0] mstatus_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic        redirect_q;
  logic        flush_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] csr_old;
  logic [31:0] csr_new;
  logic        exc_take;

  // Cause 2'b11 is not a real trap and falls through like NOT_EXCEPTION.
  assign exc_take = (bus.exception_cause != NOT_EXCEPTION) &&
                    ((bus.exception_cause == I_ADDR_MISALIGNMENT) ||
                     (bus.exception_cause == ILLEGAL_IR));

  always_comb begin
    csr_old = 32'd0;
    case (bus.csr_addr)
      A_MSTATUS:  csr_old = mstatus_q | 32'h0000_1800;
      A_MTVEC:    csr_old = mtvec_q;
      A_MSCRATCH: csr_old = mscratch_q;
      A_MEPC:     csr_old = mepc_q;
      A_MCAUSE:   csr_old = mcause_q;
      A_MTVAL:    csr_old = mtval_q;
      default:    csr_old = 32'd0;
    endcase
  end

  always_comb begin
    csr_new = csr_old;
    case (bus.csr_op)
      2'b01:   csr_new = bus.csr_wdata;
      2'b10:   csr_new = csr_old | bus.csr_wdata;
      2'b11:   csr_new = csr_old & ~bus.csr_wdata;
      default: csr_new = csr_old;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      flush_cnt     <= 2'd0;
      mstatus_q     <= 32'd0;
      mtvec_q       <= MTVEC_RESET & 32'hFFFF_FFFC;
      mscratch_q    <= 32'd0;
      mepc_q        <= 32'd0;
      mcause_q      <= 32'd0;
      mtval_q       <= 32'd0;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (exc_take) begin
            mepc_q        <= bus.exception_epc & 32'hFFFF_FFFC;
            mtval_q       <= bus.exception_tval;
            mcause_q      <= (bus.exception_cause == ILLEGAL_IR) ? 32'd2 : 32'd0;
            mstatus_q[7]  <= mstatus_q[3];
            mstatus_q[3]  <= 1'b0;
            redirect_pc_q <= mtvec_q;
            redirect_q    <= 1'b1;
            flush_q       <= 1'b1;
            state         <= REDIRECT;
          end else if (bus.mret) begin
            mstatus_q[3]  <= mstatus_q[7];
            mstatus_q[7]  <= 1'b1;
            redirect_pc_q <= mepc_q;
            redirect_q    <= 1'b1;
            flush_q       <= 1'b1;
            state         <= REDIRECT;
          end else if (bus.csr_op != 2'b00) begin
            case (bus.csr_addr)
              A_MSTATUS:  mstatus_q  <= csr_new & 32'h0000_0088;
              A_MTVEC:    mtvec_q    <= csr_new & 32'hFFFF_FFFC;
              A_MSCRATCH: mscratch_q <= csr_new;
              A_MEPC:     mepc_q     <= csr_new & 32'hFFFF_FFFC;
              A_MCAUSE:   mcause_q   <= csr_new & 32'h0000_000F;
              A_MTVAL:    mtval_q    <= csr_new;
              default:    ;
            endcase
          end
        end
        // Redirect lasts one cycle; the FLUSH state covers the remaining flush cycles.
        REDIRECT: begin
          redirect_q <= 1'b0;
          if (FLUSH_CYCLES > 1) begin
            flush_q   <= 1'b1;
            flush_cnt <= FLUSH_INIT;
            state     <= FLUSH;
          end else begin
            flush_q <= 1'b0;
            state   <= RUN;
          end
        end
        FLUSH: begin
          if (flush_cnt == 2'd0) begin
            flush_q <= 1'b0;
            state   <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 2'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.csr_rdata   = csr_old;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.flush       = flush_q;
  assign bus.mepc_out    = mepc_q;
  assign bus.mstatus_mie = mstatus_q[3];
endmodule
